// File: rtl/bidir_bus_ctrl_if.sv
// rtl/bidir_bus_ctrl_if.sv - request/ack and IO-buffer pad bundle for bidir_bus_ctrl
//
// Signals:
//   req, wr, wdata : transfer request from core logic (sampled when busy=0)
//   busy, ack      : transfer in progress / one-cycle completion pulse
//   rdata          : last captured read data
//   pad_i          : data to IO buffer inputs
//   pad_t          : IO buffer tristate control, 1 = released (high-Z)
//   pad_o          : data from IO buffer outputs
// Modports:
//   slave  : the controller
//   master : core logic plus IO buffer bank
interface bidir_bus_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             req;
    logic             wr;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             ack;
    logic [WIDTH-1:0] rdata;
    logic [WIDTH-1:0] pad_i;
    logic             pad_t;
    logic [WIDTH-1:0] pad_o;

    modport slave (
        input  req, wr, wdata, pad_o,
        output busy, ack, rdata, pad_i, pad_t
    );

    modport master (
        output req, wr, wdata, pad_o,
        input  busy, ack, rdata, pad_i, pad_t
    );
endinterface

// File: rtl/bidir_bus_ctrl.sv
// rtl/bidir_bus_ctrl.sv - half-duplex sequencer for a tri-state bidirectional data bus
//
// Ports:
//   clk   : clock, all state changes on the rising edge
//   rst_n : asynchronous active-low reset; releases the bus immediately
//   bus   : bidir_bus_ctrl_if.slave (req/wr/wdata in, busy/ack/rdata out,
//           pad_i/pad_t to IO buffers, pad_o from IO buffers)
// Parameters:
//   WIDTH   : data width
//   DRV_CYC : cycles the bus is driven per write (1..15)
//   TA_CYC  : released turnaround cycles after a write before ack (0..15)
//   RD_LAT  : edges from read accept to capture of pad_o (1..15)
module bidir_bus_ctrl #(
    parameter int WIDTH   = 8,
    parameter int DRV_CYC = 1,
    parameter int TA_CYC  = 1,
    parameter int RD_LAT  = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    bidir_bus_ctrl_if.slave     bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_TURN  = 2'd2,
        S_WAIT  = 2'd3
    } state_t;

    // The shared down-counter holds "edges remaining minus one" in the
    // current phase, so a phase ends on the edge where it reads zero.
    localparam logic [3:0] DRV_LOAD = 4'(DRV_CYC - 1);
    localparam logic [3:0] TA_LOAD  = 4'(TA_CYC - 1);
    localparam logic [3:0] RD_LOAD  = 4'(RD_LAT - 1);
    localparam bit         HAS_TURN = (TA_CYC != 0);

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             pad_t_q, pad_t_d;
    logic [WIDTH-1:0] pad_i_q, pad_i_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             ack_q, ack_d;
    logic             busy_q, busy_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            pad_t_q <= 1'b1;
            pad_i_q <= '0;
            rdata_q <= '0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pad_t_q <= pad_t_d;
            pad_i_q <= pad_i_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
        end
    end

    // Outputs are computed for the state being entered, so every pad and
    // handshake signal comes straight from a flop.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pad_t_d = 1'b1;
        pad_i_d = pad_i_q;
        rdata_d = rdata_q;
        ack_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.req) begin
                    if (bus.wr) begin
                        state_d = S_DRIVE;
                        cnt_d   = DRV_LOAD;
                        pad_t_d = 1'b0;
                        pad_i_d = bus.wdata;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = RD_LOAD;
                    end
                end
            end
            S_DRIVE: begin
                if (cnt_q == 4'd0) begin
                    if (HAS_TURN) begin
                        state_d = S_TURN;
                        cnt_d   = TA_LOAD;
                    end else begin
                        state_d = S_IDLE;
                        ack_d   = 1'b1;
                    end
                end else begin
                    cnt_d   = cnt_q - 4'd1;
                    pad_t_d = 1'b0;
                end
            end
            S_TURN: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_IDLE;
                    ack_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_IDLE;
                    ack_d   = 1'b1;
                    rdata_d = bus.pad_o;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    assign bus.busy  = busy_q;
    assign bus.ack   = ack_q;
    assign bus.rdata = rdata_q;
    assign bus.pad_i = pad_i_q;
    assign bus.pad_t = pad_t_q;
endmodule

// File: tb/tb_bidir_bus_ctrl.sv
// tb/tb_bidir_bus_ctrl.sv - self-checking bench for bidir_bus_ctrl (three parameter sets)
module tb_bidir_bus_ctrl;
    localparam int NI = 3;

    logic       clk;
    logic       rst_n;
    logic       req;
    logic       wr;
    logic [7:0] wdata;
    logic [7:0] pad_o;

    int vectors;
    int miscompares;

    // Instance 0: defaults. Instance 1: TA_CYC=0, DRV_CYC=3. Instance 2: RD_LAT=1.
    function automatic int p_drv(int i);
        case (i)
            0: return 1;
            1: return 3;
            default: return 2;
        endcase
    endfunction

    function automatic int p_ta(int i);
        case (i)
            0: return 1;
            1: return 0;
            default: return 2;
        endcase
    endfunction

    function automatic int p_rd(int i);
        case (i)
            0: return 2;
            1: return 3;
            default: return 1;
        endcase
    endfunction

    bidir_bus_ctrl_if #(.WIDTH(8)) bus0 ();
    bidir_bus_ctrl_if #(.WIDTH(8)) bus1 ();
    bidir_bus_ctrl_if #(.WIDTH(8)) bus2 ();

    assign bus0.req = req;  assign bus0.wr = wr;  assign bus0.wdata = wdata;  assign bus0.pad_o = pad_o;
    assign bus1.req = req;  assign bus1.wr = wr;  assign bus1.wdata = wdata;  assign bus1.pad_o = pad_o;
    assign bus2.req = req;  assign bus2.wr = wr;  assign bus2.wdata = wdata;  assign bus2.pad_o = pad_o;

    bidir_bus_ctrl #(.WIDTH(8), .DRV_CYC(1), .TA_CYC(1), .RD_LAT(2)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0.slave));
    bidir_bus_ctrl #(.WIDTH(8), .DRV_CYC(3), .TA_CYC(0), .RD_LAT(3)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1.slave));
    bidir_bus_ctrl #(.WIDTH(8), .DRV_CYC(2), .TA_CYC(2), .RD_LAT(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2.slave));

    logic       o_busy  [NI];
    logic       o_ack   [NI];
    logic       o_pad_t [NI];
    logic [7:0] o_pad_i [NI];
    logic [7:0] o_rdata [NI];

    assign o_busy[0] = bus0.busy;  assign o_ack[0] = bus0.ack;  assign o_pad_t[0] = bus0.pad_t;
    assign o_pad_i[0] = bus0.pad_i; assign o_rdata[0] = bus0.rdata;
    assign o_busy[1] = bus1.busy;  assign o_ack[1] = bus1.ack;  assign o_pad_t[1] = bus1.pad_t;
    assign o_pad_i[1] = bus1.pad_i; assign o_rdata[1] = bus1.rdata;
    assign o_busy[2] = bus2.busy;  assign o_ack[2] = bus2.ack;  assign o_pad_t[2] = bus2.pad_t;
    assign o_pad_i[2] = bus2.pad_i; assign o_rdata[2] = bus2.rdata;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Transaction-level reference: each instance is either idle or a known
    // number of edges ("age") into a transfer; outputs are functions of age.
    bit         m_act   [NI];
    int         m_age   [NI];
    bit         m_wr    [NI];
    logic [7:0] m_pad_i [NI];
    logic [7:0] m_rdata [NI];

    function automatic int m_len(int i);
        return m_wr[i] ? (p_drv(i) + p_ta(i)) : p_rd(i);
    endfunction

    function automatic bit exp_busy(int i);
        return m_act[i] && (m_age[i] < m_len(i));
    endfunction

    function automatic bit exp_ack(int i);
        return m_act[i] && (m_age[i] == m_len(i));
    endfunction

    function automatic bit exp_pad_t(int i);
        return !(m_act[i] && m_wr[i] && (m_age[i] < p_drv(i)));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            m_act[i]   = 1'b0;
            m_age[i]   = 0;
            m_wr[i]    = 1'b0;
            m_pad_i[i] = 8'h00;
            m_rdata[i] = 8'h00;
        end
    endtask

    // Advance the model across the coming rising edge using current inputs.
    task automatic model_step();
        if (!rst_n) begin
            model_reset();
        end else begin
            for (int i = 0; i < NI; i++) begin
                if (!exp_busy(i)) begin
                    if (req) begin
                        m_act[i] = 1'b1;
                        m_age[i] = 0;
                        m_wr[i]  = wr;
                        if (wr) m_pad_i[i] = wdata;
                    end else begin
                        m_act[i] = 1'b0;
                    end
                end else begin
                    m_age[i] = m_age[i] + 1;
                end
                if (m_act[i] && !m_wr[i] && m_age[i] == p_rd(i))
                    m_rdata[i] = pad_o;
            end
        end
    endtask

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all(input string phase);
        for (int i = 0; i < NI; i++) begin
            check_eq($sformatf("%s busy[%0d]", phase, i),  32'(o_busy[i]),  32'(exp_busy(i)));
            check_eq($sformatf("%s ack[%0d]", phase, i),   32'(o_ack[i]),   32'(exp_ack(i)));
            check_eq($sformatf("%s pad_t[%0d]", phase, i), 32'(o_pad_t[i]), 32'(exp_pad_t(i)));
            check_eq($sformatf("%s pad_i[%0d]", phase, i), 32'(o_pad_i[i]), 32'(m_pad_i[i]));
            check_eq($sformatf("%s rdata[%0d]", phase, i), 32'(o_rdata[i]), 32'(m_rdata[i]));
        end
    endtask

    // Called at a falling edge with inputs already set for the next rising edge.
    task automatic cycle(input string phase);
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_all(phase);
    endtask

    task automatic idle_cycles(input int n, input string phase);
        req = 1'b0;
        for (int k = 0; k < n; k++) cycle(phase);
    endtask

    task automatic issue(input bit w, input logic [7:0] d, input string phase);
        req   = 1'b1;
        wr    = w;
        wdata = d;
        cycle(phase);
        req   = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        req   = 1'b0;
        wr    = 1'b0;
        wdata = 8'h00;
        pad_o = 8'h00;
        rst_n = 1'b0;
        model_reset();

        @(negedge clk);
        for (int k = 0; k < 3; k++) cycle("reset");
        rst_n = 1'b1;
        idle_cycles(2, "post_reset");

        issue(1'b1, 8'h3C, "wr_3c");
        idle_cycles(5, "wr_3c");

        pad_o = 8'hA5;
        issue(1'b0, 8'h00, "rd_a5");
        idle_cycles(5, "rd_a5");

        issue(1'b1, 8'h11, "wr_11");
        idle_cycles(6, "wr_11");

        // Write followed by a read with req held high.
        issue(1'b1, 8'h55, "b2b");
        req = 1'b1;
        wr  = 1'b0;
        pad_o = 8'h3E;
        cycle("b2b");
        cycle("b2b");
        idle_cycles(7, "b2b");

        // Request during a write's turnaround must be ignored.
        issue(1'b1, 8'h77, "busy");
        cycle("busy");
        issue(1'b1, 8'h99, "busy");
        idle_cycles(7, "busy");

        for (int k = 0; k < 600; k++) begin
            req   = ($urandom_range(0, 99) < 55);
            wr    = $urandom_range(0, 1);
            wdata = 8'($urandom);
            pad_o = 8'($urandom);
            cycle("rand");
        end
        idle_cycles(8, "drain");

        // Asynchronous reset during DRIVE: bus released before the next edge.
        issue(1'b1, 8'hC3, "abort");
        #1;
        rst_n = 1'b0;
        #1;
        model_reset();
        for (int i = 0; i < NI; i++) begin
            check_eq($sformatf("abort pad_t[%0d]", i), 32'(o_pad_t[i]), 32'd1);
            check_eq($sformatf("abort busy[%0d]", i),  32'(o_busy[i]),  32'd0);
            check_eq($sformatf("abort pad_i[%0d]", i), 32'(o_pad_i[i]), 32'd0);
        end
        cycle("abort_hold");
        rst_n = 1'b1;
        idle_cycles(6, "abort_after");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/bidir_bus_ctrl.md
# bidir_bus_ctrl

Half-duplex controller for a shared bidirectional data bus built from tri-state IO buffers. It owns the buffer controls: output data to the buffer input, output enable to the buffer tristate control (1 = high-Z), and read data back from the buffer output. It sequences write drive, bus turnaround and read capture behind a simple request/acknowledge interface. It sits between core logic and a WIDTH-bit bank of IO buffers.

## Interface
Parameters:
- WIDTH, 8, data bus width in bits.
- DRV_CYC, 1, cycles the bus is actively driven per write (1..15).
- TA_CYC, 1, released turnaround cycles after a write before acknowledge (0..15).
- RD_LAT, 2, cycles from read accept to capture of PAD_O (1..15).

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- RST_N  in  1  reset, asynchronous, active-low.
- REQ  in  1  transfer request; sampled only when BUSY=0.
- WR  in  1  1 = write, 0 = read; sampled with REQ.
- WDATA  in  WIDTH  write data; sampled with REQ.
- BUSY  out  1  transfer in progress; REQ ignored while high.
- ACK  out  1  one-cycle pulse: transfer complete.
- RDATA  out  WIDTH  last captured read data.
- PAD_I  out  WIDTH  data to IO buffer inputs.
- PAD_T  out  1  tristate control to IO buffers; 1 = released (high-Z).
- PAD_O  in  WIDTH  data from IO buffer outputs.

## Operation
- States: IDLE, DRIVE, TURN, WAIT.
- Reset (RST_N=0, asynchronous): state IDLE, PAD_T=1 immediately (bus released without waiting for a clock), PAD_I=0, RDATA=0, ACK=0, BUSY=0. Applies mid-transfer; the transfer is dropped with no ACK.
- All outputs registered. Bus is released (PAD_T=1) in every state except DRIVE.
- IDLE: BUSY=0. REQ=1 at an edge accepts; WR and WDATA are latched at that edge.
- Write: IDLE -> DRIVE. PAD_T=0, PAD_I=latched WDATA for DRV_CYC cycles. Then -> TURN with PAD_T=1 for TA_CYC cycles, then -> IDLE with ACK=1. TA_CYC=0: DRIVE -> IDLE directly.
- Read: IDLE -> WAIT, PAD_T=1. PAD_O is sampled into RDATA at the RD_LAT-th edge after accept, and the state returns to IDLE with ACK=1.
- PAD_I holds the last written value outside DRIVE. RDATA holds until the next read capture; writes never alter RDATA.
- ACK is high only in the first IDLE cycle after a transfer. A new REQ may be accepted at the edge ending that cycle, so back-to-back transfers are allowed.
- Mode-switch guarantee: PAD_T is never 0 in a cycle adjacent to a read capture, provided TA_CYC>=1.
- One internal 4-bit down-counter serves DRIVE, TURN and WAIT.

## Timing
- Accept at edge k.
- Write:
  - PAD_T=0 after edges k .. k+DRV_CYC-1.
  - PAD_T=1 from edge k+DRV_CYC.
  - ACK high for the cycle after edge k+DRV_CYC+TA_CYC.
  - Latency from accept to ACK: DRV_CYC+TA_CYC+1 cycles (defaults: 3).
- Read:
  - Capture at edge k+RD_LAT.
  - ACK and the new RDATA are visible in the same cycle after that edge.
  - Latency from accept to ACK: RD_LAT+1 cycles (defaults: 3).
- BUSY is high from edge k until the edge that raises ACK, and low in the ACK cycle.
- REQ held continuously gives back-to-back transfers with no idle gap beyond the ACK cycle.

## Test plan
- Reset: hold RST_N=0 for 3 cycles -> PAD_T=1, PAD_I=0x00, RDATA=0x00, ACK=0, BUSY=0. Release -> outputs unchanged until a REQ.
- Write with defaults: REQ=1, WR=1, WDATA=0x3C at edge 0.
  - PAD_T=0 and PAD_I=0x3C for exactly one cycle after edge 0.
  - PAD_T=1 after edge 1.
  - ACK=1 only in the cycle after edge 2.
- Read with defaults: PAD_O=0xA5 stable, REQ=1, WR=0 at edge 0.
  - PAD_T stays 1 throughout.
  - After edge 2: RDATA=0xA5 and ACK=1 for one cycle.
  - RDATA stays 0xA5 after a following write of 0x11.
- Back-to-back: write 0x55, then a read with REQ held high.
  - The read is accepted in the write's ACK cycle.
  - PAD_T=0 for 1 cycle, then 1 for the rest of the sequence.
  - Exactly two ACK pulses, 3 cycles apart.
- Busy/abort: assert REQ with WDATA=0x99 during a write's TURN cycle -> ignored, PAD_I stays at the prior value. Separately, pulse RST_N low during DRIVE -> PAD_T=1 before the next edge, and no ACK follows.
- Parameter corners:
  - TA_CYC=0, DRV_CYC=3: PAD_T=0 for 3 cycles, then ACK in the next cycle.
  - RD_LAT=1: ACK 2 cycles after accept, with RDATA equal to PAD_O at edge k+1.
